// File: rtl/push_button_debouncer.sv
// Push-button debouncer: 2-flop sync, 4-state debounce FSM, registered pulses.
// Define AUTO_REPEAT_EN to add press auto-repeat while the button is held.
module push_button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic input_clock1_1,
  input  logic input_reset1_2,
  input  logic input_push_button1_3,
  output logic output_level_debounced_1,
  output logic output_pulse_press_4,
  output logic output_pulse_release_5,
  output logic output_busy_6
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          sync1;
  logic          sync2;
  logic          press_evt;
  logic          press_evt_nx;
  logic          rel_evt;
  logic          rel_evt_nx;
  logic          cnt_done;
  logic          rep_fire;

  assign cnt_done = (cnt == CW'(DEBOUNCE_CYCLES - 1));

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nx;

  assign rep_fire = (state == PRESSED) && sync2 && (rcnt == '0);

  // Reload the delay on every entry to PRESSED, period after each repeat
  always_comb begin
    rcnt_nx = '0;
    if (state_nx == PRESSED) begin
      if (state != PRESSED)
        rcnt_nx = RW'(REPEAT_DELAY - 1);
      else if (rcnt == '0)
        rcnt_nx = RW'(REPEAT_PERIOD - 1);
      else
        rcnt_nx = rcnt - 1'b1;
    end
  end

  always_ff @(posedge input_clock1_1) begin
    if (input_reset1_2)
      rcnt <= '0;
    else
      rcnt <= rcnt_nx;
  end
`else
  logic unused_repeat_cfg;

  assign rep_fire = 1'b0;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  always_ff @(posedge input_clock1_1) begin
    if (input_reset1_2) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      press_evt <= 1'b0;
      rel_evt   <= 1'b0;
    end else begin
      sync1     <= input_push_button1_3;
      sync2     <= sync1;
      state     <= state_nx;
      cnt       <= cnt_nx;
      press_evt <= press_evt_nx;
      rel_evt   <= rel_evt_nx;
    end
  end

  // A mismatching sample wins over count completion in both WAIT states
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    press_evt_nx = 1'b0;
    rel_evt_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync2) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt_done) begin
          state_nx     = PRESSED;
          cnt_nx       = '0;
          press_evt_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync2) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = '0;
        end else begin
          press_evt_nx = rep_fire;
        end
      end
      RELEASE_WAIT: begin
        if (sync2) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
        end else if (cnt_done) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          rel_evt_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge input_clock1_1) begin
    if (input_reset1_2) begin
      output_level_debounced_1 <= 1'b0;
      output_pulse_press_4     <= 1'b0;
      output_pulse_release_5   <= 1'b0;
      output_busy_6            <= 1'b0;
    end else begin
      output_level_debounced_1 <= (state == PRESSED) ||
                                  (state == RELEASE_WAIT);
      output_pulse_press_4     <= press_evt;
      output_pulse_release_5   <= rel_evt;
      output_busy_6            <= (state == PRESS_WAIT) ||
                                  (state == RELEASE_WAIT);
    end
  end

endmodule

// File: tb/tb_push_button_debouncer.sv
// Bench for push_button_debouncer: directed steps plus random bouncing,
// checked against a streak-counting model of the debounce rules.
module tb_push_button_debouncer;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic lvl;
  logic prs;
  logic rel;
  logic bsy;

  int n_vec = 0;
  int n_err = 0;

  push_button_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .input_clock1_1          (clk),
    .input_reset1_2          (rst),
    .input_push_button1_3    (btn),
    .output_level_debounced_1(lvl),
    .output_pulse_press_4    (prs),
    .output_pulse_release_5  (rel),
    .output_busy_6           (bsy)
  );

  always #5 clk = ~clk;

  // Model: button seen by the debouncer two edges late; level flips once
  // D+1 consecutive samples disagree with it; outputs lag one edge.
  logic m_d1, m_d2, m_level, m_evp, m_evr;
  int   m_streak;
  int   m_hold;
  logic e_lvl, e_prs, e_rel, e_bsy;

  task automatic model_edge(input logic b, input logic r);
    logic seen;
    if (r) begin
      m_d1 = 0; m_d2 = 0; m_level = 0;
      m_evp = 0; m_evr = 0;
      m_streak = 0; m_hold = 0;
      e_lvl = 0; e_prs = 0; e_rel = 0; e_bsy = 0;
    end else begin
      e_lvl = m_level;
      e_bsy = (m_streak != 0);
      e_prs = m_evp;
      e_rel = m_evr;
      seen  = m_d2;
      m_evp = 0;
      m_evr = 0;
      if (seen != m_level) begin
        m_hold = 0;
        m_streak++;
        if (m_streak == D + 1) begin
          m_level  = seen;
          m_streak = 0;
          if (seen) m_evp = 1;
          else m_evr = 1;
        end
      end else begin
`ifdef AUTO_REPEAT_EN
        if (m_level && m_streak == 0) begin
          m_hold++;
          if (m_hold >= RD && (m_hold - RD) % RP == 0)
            m_evp = 1;
        end else begin
          m_hold = 0;
        end
`endif
        m_streak = 0;
      end
      m_d2 = m_d1;
      m_d1 = b;
    end
  endtask

  task automatic check(input string tag,
                       input logic obs,
                       input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag,
                           input int obs,
                           input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic r);
    btn = b;
    rst = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    check("level", lvl, e_lvl);
    check("press", prs, e_prs);
    check("release", rel, e_rel);
    check("busy", bsy, e_bsy);
  endtask

  initial begin
    int first;
    int npress;
    logic [3:0] disp;
    logic [11:0] bounce;

    // Reset with button held, then press accepted D+3 edges later
    step(1, 1);
    step(1, 1);
    check("rst_lvl", lvl, 1'b0);
    check("rst_prs", prs, 1'b0);
    first = -1;
    for (int i = 0; i < 12; i++) begin
      step(1, 0);
      if (prs && first < 0) first = i;
    end
    check_int("rst_press_lat", first, D + 3);

    step(0, 1);
    for (int i = 0; i < 10; i++) step(0, 0);

    // Clean press and release
    first = -1;
    npress = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0);
      if (prs) npress++;
      if (prs && first < 0) first = i;
    end
    check_int("clean_press_at", first, D + 3);
`ifndef AUTO_REPEAT_EN
    check_int("clean_npress", npress, 1);
`endif
    first = -1;
    for (int i = 0; i < 12; i++) begin
      step(0, 0);
      if (rel && first < 0) first = i;
      if (i == D + 2) check("lvl_before_fall", lvl, 1'b1);
      if (i == D + 3) check("lvl_after_fall", lvl, 1'b0);
    end
    check_int("clean_release_at", first, D + 3);

    // Bounce shorter than the debounce window
    bounce = 12'b000000111011;
    npress = 0;
    for (int i = 0; i < 12; i++) begin
      step(bounce[i], 0);
      if (prs) npress++;
      if (i > 0 && i < 10) check("bounce_lvl", lvl, 1'b0);
    end
    check_int("bounce_npress", npress, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0);
      if (prs) npress++;
    end
    check_int("after_bounce_npress", npress, 1);
    for (int i = 0; i < 10; i++) step(0, 0);

    // Reset while PRESS_WAIT holds cnt=2
    for (int i = 0; i < 5; i++) step(1, 0);
    check("midcnt_busy", bsy, 1'b1);
    step(1, 1);
    check("midcnt_busy_rst", bsy, 1'b0);
    npress = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0);
      if (prs) npress++;
    end
    check_int("midcnt_npress", npress, 0);

    // Random bouncing and holds
    for (int s = 0; s < 250; s++) begin
      logic b;
      int len;
      b = 1'($urandom_range(0, 1));
      len = (($urandom & 3) == 0) ? $urandom_range(6, 30)
                                  : $urandom_range(1, 6);
      for (int i = 0; i < len; i++)
        step(b, ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 12; i++) step(0, 0);

    // Ten clean presses feeding a 4-bit display counter
    disp = 4'h0;
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 8; i++) begin
        step(1, 0);
        if (prs) disp = disp + 4'h1;
      end
      for (int i = 0; i < 8; i++) begin
        step(0, 0);
        if (prs) disp = disp + 4'h1;
      end
    end
    check_int("display_count", int'(disp), 10);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
